// File: rtl/afifo_rd_ctrl.sv
// afifo_rd_ctrl
// Read-side controller of the asynchronous FIFO (rclk domain).
// Compares the synchronized Gray write pointer against the local read
// pointer, issues memory reads, and captures returned data into a 2-entry
// output buffer that feeds a valid/ready consumer. It also exports the
// registered Gray read pointer for the write-domain synchronizer.
//
// Optional feature macro: AFIFO_RD_BYPASS_EN
//   defined   : returned data reaches dout combinationally when the buffer is empty
//   undefined : dout/dout_valid come from registers only
//
// Ports
//   rclk            read-domain clock
//   rrst            asynchronous active-high reset
//   rsrst           synchronous active-high soft reset
//   rq2_wptr_gray   write pointer, Gray, already synchronized to rclk
//   ram_ren         memory read enable
//   ram_raddr       memory read address
//   ram_rdata_valid read data valid, one cycle after ram_ren
//   ram_rdata       read data
//   dout_valid      output word valid
//   dout            output word
//   dout_ready      consumer accepts the word
//   rptr_gray       registered Gray read pointer
//   rempty          no unread words remain in memory
//   rlevel          words in memory not yet read (0..DEPTH)

module afifo_rd_ctrl #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic          rsrst,
  input  logic [AW:0]   rq2_wptr_gray,
  output logic          ram_ren,
  output logic [AW-1:0] ram_raddr,
  input  logic          ram_rdata_valid,
  input  logic [DW-1:0] ram_rdata,
  output logic          dout_valid,
  output logic [DW-1:0] dout,
  input  logic          dout_ready,
  output logic [AW:0]   rptr_gray,
  output logic          rempty,
  output logic [AW:0]   rlevel
);

  localparam int unsigned PW = AW + 1;

  // Registered state
  logic [PW-1:0] rptr_bin_q;
  logic [1:0]    occ_q;
  logic          inflight_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;

  // Next-state values
  logic [PW-1:0] rptr_bin_d;
  logic [PW-1:0] rptr_gray_d;
  logic [1:0]    occ_d;
  logic          inflight_d;
  logic [DW-1:0] head_d;
  logic [DW-1:0] tail_d;

  logic [PW-1:0] wptr_bin;
  logic          pop;
  logic          push;
  logic [2:0]    outstanding;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    wptr_bin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wptr_bin[i] = ^(rq2_wptr_gray >> i);
    end
  end

  assign rempty    = (rptr_bin_q == wptr_bin);
  assign rlevel    = wptr_bin - rptr_bin_q;
  assign ram_raddr = rptr_bin_q[AW-1:0];

  // Returning data is dropped while soft reset is active
  assign push = ram_rdata_valid & inflight_q & ~rsrst;
  assign pop  = dout_valid & dout_ready;

  // Output presentation
`ifdef AFIFO_RD_BYPASS_EN
  logic byp;
  assign byp        = (occ_q == 2'd0) & push;
  assign dout_valid = (occ_q != 2'd0) | byp;
  assign dout       = byp ? ram_rdata : head_q;
`else
  assign dout_valid = (occ_q != 2'd0);
  assign dout       = head_q;
`endif

  // Words buffered or in flight once this cycle's pop is taken out
  assign outstanding = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

  assign ram_ren = ~rempty & ~rsrst & ~rrst & (outstanding < 3'd2);

  // Next-state logic for pointer, in-flight flag and output buffer
  always_comb begin
    rptr_bin_d = rptr_bin_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (rsrst) begin
      rptr_bin_d = '0;
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (ram_ren) begin
        rptr_bin_d = rptr_bin_q + PW'(1);
      end

      // A new issue keeps the flag set even if the previous read returns now
      if (ram_ren) begin
        inflight_d = 1'b1;
      end else if (push) begin
        inflight_d = 1'b0;
      end

      // head_q is the word on dout, tail_q the word queued behind it
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = ram_rdata;
          end else begin
            tail_d = ram_rdata;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          // occ_q == 0 only with bypass: the word passes straight through
          if (occ_q == 2'd2) begin
            head_d = tail_q;
            tail_d = ram_rdata;
          end else if (occ_q == 2'd1) begin
            head_d = ram_rdata;
          end
        end
        default: begin
        end
      endcase
    end

    rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
  end

  // State register
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rptr_bin_q <= '0;
      rptr_gray  <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      rptr_bin_q <= rptr_bin_d;
      rptr_gray  <= rptr_gray_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifndef SYNTHESIS
  // Buffered plus in-flight words never exceed the buffer capacity
  always @(posedge rclk) begin
    if (!rrst) begin
      assert (3'(occ_q) + 3'(inflight_q) <= 3'd2)
        else $error("afifo_rd_ctrl: occupancy plus in-flight exceeds 2");
    end
  end
`endif

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Self-checking bench for afifo_rd_ctrl: a memory/write-side model drives the
// DUT, written words go into an expected queue, and a negedge monitor checks
// every consumer handshake and the pointer/level outputs against a word-count
// model of the FIFO.

module tb_afifo_rd_ctrl;

  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
`ifdef AFIFO_RD_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          rclk;
  logic          rrst;
  logic          rsrst;
  logic [AW:0]   rq2_wptr_gray;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic          ram_rdata_valid;
  logic [DW-1:0] ram_rdata;
  logic          dout_valid;
  logic [DW-1:0] dout;
  logic          dout_ready;
  logic [AW:0]   rptr_gray;
  logic          rempty;
  logic [AW:0]   rlevel;

  afifo_rd_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .rclk            (rclk),
    .rrst            (rrst),
    .rsrst           (rsrst),
    .rq2_wptr_gray   (rq2_wptr_gray),
    .ram_ren         (ram_ren),
    .ram_raddr       (ram_raddr),
    .ram_rdata_valid (ram_rdata_valid),
    .ram_rdata       (ram_rdata),
    .dout_valid      (dout_valid),
    .dout            (dout),
    .dout_ready      (dout_ready),
    .rptr_gray       (rptr_gray),
    .rempty          (rempty),
    .rlevel          (rlevel)
  );

  // Bench model state
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_bin      = '0;
  logic [PW-1:0] model_rptr  = '0;
  int            outstanding = 0;
  logic [DW-1:0] exp_q [$];
  logic          pend_ren    = 1'b0;
  logic [AW-1:0] pend_addr   = '0;
  logic          prev_hold   = 1'b0;
  logic [DW-1:0] prev_dout   = '0;
  int            n_checks    = 0;
  int            n_fail      = 0;

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Monitor: checks outputs against the word-count model, then updates it
  always @(negedge rclk) begin : monitor
    logic          pop_m;
    logic          empty_m;
    logic          allow_m;
    logic [DW-1:0] e;
    if (rrst) begin
      model_rptr  = '0;
      outstanding = 0;
      pend_ren    = 1'b0;
      prev_hold   = 1'b0;
    end else begin
      pop_m   = dout_valid & dout_ready;
      empty_m = (wr_bin == model_rptr);
      allow_m = !empty_m && !rsrst && (outstanding - int'(pop_m) < 2);
      chk("rempty", 32'(rempty), 32'(empty_m));
      chk("rlevel", 32'(rlevel), 32'(PW'(wr_bin - model_rptr)));
      chk("rptr_gray", 32'(rptr_gray), 32'(bin2gray(model_rptr)));
      chk("ram_ren", 32'(ram_ren), 32'(allow_m));
      if (ram_ren) chk("ram_raddr", 32'(ram_raddr), 32'(model_rptr[AW-1:0]));
      if (outstanding == 0) chk("valid_idle", 32'(dout_valid), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(dout_valid), 32'd1);
        chk("hold_dout", 32'(dout), 32'(prev_dout));
      end
      if (pop_m) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no word at %0t", dout, $time);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            n_fail++;
            $display("FAIL dout_order: got 0x%0h, expected 0x%0h at %0t", dout, e, $time);
          end
        end
      end
      if (rsrst) begin
        model_rptr  = '0;
        outstanding = 0;
        exp_q.delete();
        prev_hold   = 1'b0;
      end else begin
        model_rptr  = model_rptr + PW'(ram_ren);
        outstanding = outstanding + int'(ram_ren) - int'(pop_m);
        prev_hold   = dout_valid & !dout_ready;
        prev_dout   = dout;
      end
      pend_ren  = ram_ren;
      pend_addr = ram_raddr;
    end
  end

  // Advance one cycle and return data for the read issued last cycle
  task automatic tick();
    @(posedge rclk);
    #1;
    ram_rdata_valid = pend_ren;
    ram_rdata       = pend_ren ? mem[pend_addr] : DW'($urandom);
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wr_bin[AW-1:0]] = d;
    exp_q.push_back(d);
    wr_bin        = wr_bin + PW'(1);
    rq2_wptr_gray = bin2gray(wr_bin);
  endtask

  task automatic soft_reset();
    tick();
    rsrst         = 1'b1;
    dout_ready    = 1'b0;
    wr_bin        = '0;
    rq2_wptr_gray = '0;
    tick();
    rsrst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || outstanding != 0) && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : driver
    logic [DW-1:0] wv;
    logic [DW-1:0] w0;
    int            pops;
    int            rens;
    int            total;
    int            burst;
    int            cyc;
    int            nw;

    rrst = 1'b0; rsrst = 1'b0; rq2_wptr_gray = '0;
    ram_rdata_valid = 1'b0; ram_rdata = '0; dout_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #1 rrst = 1'b1;

    // Reset with arbitrary inputs
    repeat (4) begin
      tick();
      rsrst           = 1'($urandom);
      rq2_wptr_gray   = PW'($urandom);
      ram_rdata_valid = 1'($urandom);
      ram_rdata       = DW'($urandom);
      dout_ready      = 1'($urandom);
      @(negedge rclk);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_rptr_gray", 32'(rptr_gray), 32'd0);
      chk("rst_ram_ren", 32'(ram_ren), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
    end
    tick();
    rsrst = 1'b0; rq2_wptr_gray = '0; ram_rdata_valid = 1'b0; dout_ready = 1'b0;
    rrst = 1'b0;
    @(negedge rclk);
    chk("rel_rempty", 32'(rempty), 32'd1);
    chk("rel_rlevel", 32'(rlevel), 32'd0);

    // Full stream: 16 words visible at once
    tick();
    dout_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_word(DW'($urandom));
    pops = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge rclk);
      if (i < DEPTH) chk("fs_ren", 32'({ram_ren, ram_raddr}), 32'({1'b1, AW'(i)}));
      pops += int'(dout_valid & dout_ready);
      tick();
    end
    @(negedge rclk);
    chk("fs_pops", 32'(pops), 32'(DEPTH));
    chk("fs_rptr_gray", 32'(rptr_gray), 32'h18);
    chk("fs_rempty", 32'(rempty), 32'd1);

    // Single word from pointer 0
    soft_reset();
    dout_ready = 1'b1;
    wv = DW'($urandom);
    write_word(wv);
    @(negedge rclk);
    chk("sw_ren", 32'(ram_ren), 32'd1);
    chk("sw_raddr", 32'(ram_raddr), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge rclk);
      chk("sw_valid", 32'(dout_valid), 32'(k == LAT));
      if (k == LAT) chk("sw_dout", 32'(dout), 32'(wv));
    end
    chk("sw_rptr_gray", 32'(rptr_gray), 32'd1);
    chk("sw_rempty", 32'(rempty), 32'd1);

    // Soft reset in the cycle the first read returns
    tick();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_word(DW'($urandom));
    @(negedge rclk);
    chk("sr_ren", 32'(ram_ren), 32'd1);
    tick();
    rsrst = 1'b1; wr_bin = '0; rq2_wptr_gray = '0;
    tick();
    rsrst = 1'b0;
    @(negedge rclk);
    chk("sr_valid", 32'(dout_valid), 32'd0);
    chk("sr_rptr_gray", 32'(rptr_gray), 32'd0);
    chk("sr_dout", 32'(dout), 32'd0);
    tick();
    @(negedge rclk);
    chk("sr_valid_late", 32'(dout_valid), 32'd0);

    // Backpressure: 5 words, consumer stalled
    tick();
    dout_ready = 1'b0;
    w0 = DW'($urandom);
    write_word(w0);
    for (int i = 0; i < 4; i++) write_word(DW'($urandom));
    rens = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge rclk);
      rens += int'(ram_ren);
      if (k == 5) begin
        chk("bp_rens", 32'(rens), 32'd2);
        chk("bp_rlevel", 32'(rlevel), 32'd3);
        chk("bp_valid", 32'(dout_valid), 32'd1);
        chk("bp_dout", 32'(dout), 32'(w0));
      end
      tick();
    end
    dout_ready = 1'b1;
    wait_drain(40, "bp_drain");

    // Randomized bursts across pointer wrap
    total = 0; burst = 0; cyc = 0;
    while (total < 80 && cyc < 5000) begin
      tick();
      cyc++;
      dout_ready = ($urandom_range(0, 3) != 0);
      if (burst == 0 && $urandom_range(0, 3) == 0) burst = $urandom_range(1, 16);
      nw = $urandom_range(1, 2);
      for (int j = 0; j < nw; j++) begin
        if (burst > 0 && total < 80 && int'(PW'(wr_bin - model_rptr)) < DEPTH) begin
          write_word(DW'($urandom));
          burst--;
          total++;
        end
      end
    end
    chk("wrap_written", 32'(total), 32'd80);
    dout_ready = 1'b1;
    wait_drain(80, "wrap_drain");
    @(negedge rclk);
    chk("wrap_rptr_gray", 32'(rptr_gray), 32'(bin2gray(wr_bin)));
    chk("wrap_rempty", 32'(rempty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
